// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD sector-read arbiter.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_BUSY
    } arb_state_t;

    localparam int CLIENT_FDC_A = 0;
    localparam int CLIENT_FDC_B = 1;
    localparam int CLIENT_ACSI  = 2;

    localparam int TMO_W = 24;

    function automatic logic [1:0] slot_onehot(input logic drive);
        return drive ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sd_sector_arbiter_if.sv
// Sector-read port of the SD card wrapper as seen by the arbiter.
interface sd_sector_arbiter_if;
    import sd_arb_pkg::*;

    logic [1:0]  image_mounted;
    logic [1:0]  rstart;
    logic [31:0] rsector;
    logic        rbusy;
    logic        rdone;
    logic        outen;
    logic [8:0]  outaddr;
    logic [7:0]  outbyte;

    modport master (
        output rstart, rsector,
        input  image_mounted, rbusy, rdone,
        input  outen, outaddr, outbyte
    );

    modport slave (
        input  rstart, rsector,
        output image_mounted, rbusy, rdone,
        output outen, outaddr, outbyte
    );

endinterface

// File: rtl/sd_sector_arbiter_rr_pick.sv
// Round-robin first-set finder: first pending client at or after rr_ptr.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] rr_ptr,
    output logic          valid,
    output logic [IW-1:0] grant
);

    int j;

    // Walk from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N) j = j - N;
            if (pending[j]) begin
                valid = 1'b1;
                grant = IW'(j);
            end
        end
    end

endmodule

// File: rtl/sd_sector_arbiter.sv
// Shares the SD wrapper sector-read port among several requesters.
module sd_sector_arbiter
    import sd_arb_pkg::*;
#(
    parameter int               NUM_CLIENTS = 3,
    parameter logic [TMO_W-1:0] TIMEOUT     = 24'd8000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CLIENTS-1:0]     cl_req,
    input  logic [NUM_CLIENTS-1:0]     cl_drive,
    input  logic [32*NUM_CLIENTS-1:0]  cl_sector,
    output logic [NUM_CLIENTS-1:0]     cl_busy,
    output logic [NUM_CLIENTS-1:0]     cl_done,
    output logic [NUM_CLIENTS-1:0]     cl_err,
    output logic [NUM_CLIENTS-1:0]     cl_outen,
    output logic [8:0]                 out_addr,
    output logic [7:0]                 out_byte,
    sd_sector_arbiter_if.master        sd
);

    localparam int IW = $clog2(NUM_CLIENTS);

    arb_state_t             state;
    logic [NUM_CLIENTS-1:0] pending;
    logic [NUM_CLIENTS-1:0] drive_q;
    logic [31:0]            sector_q [NUM_CLIENTS];
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          grant;
    logic [TMO_W-1:0]       timer;
    logic [1:0]             rstart_q;
    logic [31:0]            rsector_q;
    logic [NUM_CLIENTS-1:0] done_q;
    logic [NUM_CLIENTS-1:0] err_q;

    logic                   pick_vld;
    logic [IW-1:0]          pick_idx;
    logic [NUM_CLIENTS-1:0] grant_oh;
    logic [NUM_CLIENTS-1:0] accept;
    logic [NUM_CLIENTS-1:0] clr;
    logic                   g_drive;

    rr_pick #(
        .N  (NUM_CLIENTS),
        .IW (IW)
    ) u_pick (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .valid   (pick_vld),
        .grant   (pick_idx)
    );

    assign grant_oh = NUM_CLIENTS'(1) << grant;
    assign g_drive  = drive_q[grant];
    assign cl_busy  = pending | ((state != S_IDLE) ? grant_oh : '0);
    // A re-request from a client already queued or in service is dropped.
    assign accept   = cl_req & ~cl_busy;
    assign clr      = (state == S_IDLE && pick_vld)
                    ? NUM_CLIENTS'(1) << pick_idx : '0;

    assign cl_outen   = (state == S_BUSY && sd.outen) ? grant_oh : '0;
    assign cl_done    = done_q;
    assign cl_err     = err_q;
    assign out_addr   = sd.outaddr;
    assign out_byte   = sd.outbyte;
    assign sd.rstart  = rstart_q;
    assign sd.rsector = rsector_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pending   <= '0;
            drive_q   <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            timer     <= '0;
            rstart_q  <= '0;
            rsector_q <= '0;
            done_q    <= '0;
            err_q     <= '0;
            for (int i = 0; i < NUM_CLIENTS; i++) sector_q[i] <= '0;
        end else begin
            done_q  <= '0;
            err_q   <= '0;
            pending <= (pending & ~clr) | accept;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                if (accept[i]) begin
                    drive_q[i]  <= cl_drive[i];
                    sector_q[i] <= cl_sector[32*i +: 32];
                end
            end
            unique case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        grant  <= pick_idx;
                        rr_ptr <= (pick_idx == IW'(NUM_CLIENTS - 1))
                                ? '0 : pick_idx + IW'(1);
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!sd.image_mounted[g_drive]) begin
                        done_q <= grant_oh;
                        err_q  <= grant_oh;
                        state  <= S_IDLE;
                    end else begin
                        rsector_q <= sector_q[grant];
                        rstart_q  <= slot_onehot(g_drive);
                        timer     <= '0;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    timer <= timer + TMO_W'(1);
                    // A fast rdone beats rbusy and the timeout.
                    if (sd.rdone) begin
                        rstart_q <= '0;
                        done_q   <= grant_oh;
                        state    <= S_IDLE;
                    end else if (sd.rbusy) begin
                        rstart_q <= '0;
                        state    <= S_BUSY;
                    end else if (timer == TIMEOUT - TMO_W'(1)) begin
                        rstart_q <= '0;
                        done_q   <= grant_oh;
                        err_q    <= grant_oh;
                        state    <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (sd.rdone) begin
                        done_q <= grant_oh;
                        state  <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/sd_sector_arbiter.md
Name: sd_sector_arbiter

Overview:
- Shares the single sector-read port of the SD card wrapper (rstart/rsector/rbusy/rdone plus the outen/outaddr/outbyte stream) among NUM_CLIENTS requesters, e.g. floppy A, floppy B and ACSI hard disk.
- Captures request pulses, grants round-robin, sequences one sector read at a time, and steers the sector byte stream to the granted client only.
- Completes reads targeting unmounted images immediately with an error, and aborts reads that are never picked up after TIMEOUT cycles.

Parameters:
- NUM_CLIENTS, 3: number of requesters, 2..4.
- TIMEOUT, 24'd8000000: cycles allowed in S_START before the read is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- cl_req  in  NUM_CLIENTS  per-client one-cycle request pulse.
- cl_drive  in  NUM_CLIENTS  image slot per client, 0 or 1, sampled with cl_req.
- cl_sector  in  32*NUM_CLIENTS  sector number per client, sampled with cl_req; client i occupies bits [32i+31:32i].
- cl_busy  out  NUM_CLIENTS  level, high from capture of the request until its done pulse.
- cl_done  out  NUM_CLIENTS  one-cycle completion pulse.
- cl_err  out  NUM_CLIENTS  valid only with cl_done; 1 = not mounted or timed out.
- cl_outen  out  NUM_CLIENTS  byte strobe, routed to the granted client only.
- out_addr  out  9  broadcast copy of outaddr.
- out_byte  out  8  broadcast copy of outbyte.
- image_mounted  in  2  per-slot mount state from the SD wrapper.
- rstart  out  2  one-hot slot request to the SD wrapper.
- rsector  out  32  sector to the SD wrapper.
- rbusy  in  1  from the SD wrapper.
- rdone  in  1  from the SD wrapper.
- outen  in  1  from the SD wrapper.
- outaddr  in  9  from the SD wrapper.
- outbyte  in  8  from the SD wrapper.

Behaviour:
- Reset values: rstart=0, rsector=0, all cl_* outputs=0, pending=0, state=S_IDLE, rr pointer=0, timer=0.
- Capture: cl_req[i] sets pending[i] and latches drive[i]/sector[i]. cl_busy[i] = pending[i] or (granted==i and state!=S_IDLE).
- A cl_req[i] arriving while client i is already pending or granted is ignored; the first latched request stands.
- Arbitration (S_IDLE): pick the first pending client starting at rr_ptr and wrapping modulo NUM_CLIENTS. Clear its pending bit, record it as grant, set rr_ptr = grant+1 (wrapping). Move to S_CHECK the next cycle.
- S_CHECK (1 cycle):
  - If image_mounted[drive[grant]]==0: pulse cl_done and cl_err for the grant, go to S_IDLE. Latency from an idle cl_req to cl_done is 3 cycles.
  - Otherwise drive rsector=sector[grant] and rstart = one-hot of drive[grant], clear the timer, go to S_START.
- S_START: hold rstart and rsector, increment the timer.
  - rbusy==1: clear rstart, go to S_BUSY.
  - rdone==1 seen here (fast completion): treat as S_BUSY completion, same cycle.
  - timer==TIMEOUT-1: clear rstart, pulse cl_done and cl_err, go to S_IDLE.
- S_BUSY: rsector held. cl_outen[grant] = outen combinationally; all other clients see 0. On rdone: pulse cl_done[grant] with cl_err=0 and go to S_IDLE.
- rdone and rbusy together in S_START: rdone wins.
- rdone or outen outside S_START/S_BUSY: ignored; cl_outen stays 0.
- Arbitration of the next request resumes the cycle after the done pulse. Maximum one outstanding SD read.
- out_addr and out_byte are combinational pass-through of outaddr and outbyte.
- Reset mid-operation: rstart drops the next cycle, no cl_done is emitted, and all pending requests are lost.

Decomposition:
- Shared package sd_arb_pkg holds:
  - state enum S_IDLE/S_CHECK/S_START/S_BUSY;
  - CLIENT_FDC_A=0, CLIENT_FDC_B=1, CLIENT_ACSI=2;
  - TIMEOUT width constant 24.
- One sub-module, rr_pick: combinational round-robin first-set finder, inputs pending and rr_ptr, outputs valid and grant index.

Test Plan:
- Single read: client 0 pulses cl_req with drive=0, sector=0x00001234, image_mounted=2'b01. Expect rstart=2'b01 and rsector=0x1234; rbusy high clears rstart; 512 outen strobes appear on cl_outen[0] only; rdone gives cl_done[0]=1, cl_err=0.
- Contention: clients 0, 1 and 2 pulse in the same cycle. Expect service order 0,1,2. Then clients 0 and 2 pulse again with rr_ptr=0 after wrap: expect 0 then 2, and rsector matches each client's value.
- Unmounted: client 1 requests drive=1 with image_mounted=2'b01. Expect cl_done[1] and cl_err[1] 3 cycles after cl_req, rstart never asserted.
- Timeout: set TIMEOUT=16 and never assert rbusy. Expect rstart high for 16 cycles, then cl_done and cl_err for the grant; the next pending client is then served.
- Duplicate/stray: client 2 re-pulses cl_req while busy, expect exactly one cl_done. Stray outen while S_IDLE gives all cl_outen=0.
- Reset during S_BUSY: rstart=0 and cl_busy=0 the next cycle, no cl_done. A fresh request afterwards completes normally.
